dwt_col_fwd: RTL
================

Name: dwt_col_fwd

Overview:
- Forward column Haar stage of the 2D DWT encoder path. This is the counterpart of the inverse column stage in the IDWT datapath.
- Accepts a raster stream of 64-bit row beats (8 unsigned 8-bit pixels per beat) and buffers each even row in an internal row buffer.
- While the following odd row streams in, it pairs each odd beat with the stored even beat and emits one low-band (L) and one high-band (H) 64-bit word per pair.
- Sits between the row-transform output and the compression/quantiser stage.

Parameters:
- COLS, 8: 64-bit beats per image row (image width / 8); minimum 1.
- ROWS, 8: rows per frame; must be even, minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel_in holds a valid row beat.
- in_ready  out  1  block accepts pixel_in this cycle.
- pixel_in  in  64  8 pixel lanes; lane k = bits [8k+7:8k], unsigned.
- out_valid  out  1  lo_out/hi_out hold a valid band pair.
- out_ready  in  1  downstream accepts the pair this cycle.
- lo_out  out  64  low band, 8 unsigned lanes.
- hi_out  out  64  high band, 8 two's-complement lanes.
- frame_done  out  1  one-cycle pulse, last pair of the frame loaded.

Behaviour:
- Reset (async, rst=1):
  - state=EVEN, col_cnt=0, pair_cnt=0.
  - out_valid=0, lo_out=0, hi_out=0, frame_done=0.
  - Row buffer contents are don't-care and are never read before being rewritten.
- A transfer occurs when in_valid && in_ready. The output handshake completes when out_valid && out_ready.
- in_ready is combinational:
  - 1 in EVEN.
  - In ODD: !out_valid || out_ready.
- EVEN state, on each transfer:
  - rowbuf[col_cnt] <= pixel_in; no output is produced.
  - col_cnt increments. At col_cnt==COLS-1 it wraps to 0 and state goes to ODD.
- ODD state, on each transfer, per lane k (e = rowbuf[col_cnt] lane k, o = pixel_in lane k):
  - s = e + o, 9-bit unsigned; L = s[8:1].
  - d = e - o, 9-bit two's complement; H = d[8:1] (arithmetic >>1).
  - lo_out/hi_out are registered and out_valid=1 on the next edge. Latency is 1 cycle from the odd beat to the output.
  - col_cnt increments. At COLS-1 it wraps to 0, state goes to EVEN, and pair_cnt increments.
  - When pair_cnt==ROWS/2-1 at that wrap, pair_cnt goes to 0 and frame_done=1 for exactly one cycle, coincident with out_valid rising for that last pair.
- out_valid:
  - Clears after a completed output handshake with no new load.
  - A simultaneous output handshake and new load keeps out_valid=1 with the new data.
- Backpressure:
  - Holding out_ready=0 stalls ODD-row intake.
  - lo_out/hi_out stay stable while out_valid && !out_ready.
  - EVEN-row intake is never stalled by the output; a pending output may remain valid across an entire EVEN row.
- in_valid=0 inserts bubbles. Counters do not advance.
- Reconstruction: e = L+H and o = L-H (mod 256), exact when e+o is even, LSB-lossy otherwise. When driving the inverse column stage, hi_out connects to its first operand and lo_out to its second.
- Reset mid-row or mid-frame aborts the frame. Counters and state return to their reset values immediately and any pending output is dropped. The next beat is treated as row 0, column 0.

Decomposition:
- Package dwt_pkg:
  - LANE_W=8, LANES=8, BEAT_W=64.
  - typedef pix_t (8-bit unsigned), band_t (8-bit signed).
  - typedef enum {EVEN, ODD} col_state_t.
- Sub-module haar_lane_fwd:
  - Combinational, one lane: inputs e, o (8-bit); outputs L, H.
  - Instantiated 8 times via generate.
- Top-level dwt_col_fwd holds the row buffer, counters, FSM and output register.

Test Plan (COLS=2, ROWS=4 unless stated):
- Reset mid-row-1 after one odd beat accepted -> out_valid=0, frame_done=0 immediately. The next 2 beats are buffered as an even row with no output produced.
- Even row all lanes 200, odd row all lanes 100 -> two output beats, lo_out lanes 0x96, hi_out lanes 0x32, each one cycle after the odd beat.
- Even row 100, odd row 200 -> lo_out lanes 0x96, hi_out lanes 0xCE (-50).
- Even row 255, odd row 0 -> lo_out lanes 0x7F, hi_out lanes 0x7F. Lane 0 with e=0, o=255 -> lo 0x7F, hi 0x80.
- out_ready=0 during an odd row -> in_ready=0 after the first pair loads and outputs hold stable. Releasing out_ready drains the pair and resumes intake with no loss or duplication.
- Stream a full 4-row frame with random bubbles -> exactly 4 output pairs, frame_done pulses once with the 4th pair. A second frame follows with identical behaviour.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared widths, pixel/band types and the column-stage state encoding.
package dwt_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 8;
    localparam int BEAT_W = LANE_W * LANES;

    typedef logic [LANE_W-1:0]        pix_t;
    typedef logic signed [LANE_W-1:0] band_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } col_state_t;

endpackage

// File: rtl/haar_lane_fwd.sv
// One lane of the forward Haar butterfly: L = (e+o)>>1, H = (e-o)>>>1.
module haar_lane_fwd
    import dwt_pkg::*;
(
    input  pix_t  e,
    input  pix_t  o,
    output pix_t  l,
    output band_t h
);

    logic [LANE_W:0] sum;
    logic [LANE_W:0] diff;

    // Widen by one bit so neither the sum carry nor the difference sign is lost.
    always_comb begin
        sum  = {1'b0, e} + {1'b0, o};
        diff = {1'b0, e} - {1'b0, o};
        l    = sum[LANE_W:1];
        h    = band_t'(diff[LANE_W:1]);
    end

endmodule

// File: rtl/dwt_col_fwd.sv
// Forward column Haar stage: buffers each even row, pairs it with the
// following odd row and emits one registered L/H band pair per odd beat.
module dwt_col_fwd
    import dwt_pkg::*;
#(
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] pixel_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] lo_out,
    output logic [BEAT_W-1:0] hi_out,
    output logic              frame_done
);

    localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PAIRS = ROWS / 2;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0]  COL_LAST  = CNT_W'(COLS - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(PAIRS - 1);

    // Even-row storage; each entry is rewritten before the odd row reads it.
    logic [BEAT_W-1:0] rowbuf_q [COLS];

    col_state_t        state_q, state_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BEAT_W-1:0] lo_q, lo_d;
    logic [BEAT_W-1:0] hi_q, hi_d;
    logic              frame_done_q, frame_done_d;

    logic [BEAT_W-1:0] even_beat;
    logic [BEAT_W-1:0] lo_calc;
    logic [BEAT_W-1:0] hi_calc;
    logic              xfer;
    logic              rowbuf_we;

    assign even_beat = rowbuf_q[col_cnt_q];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            haar_lane_fwd u_lane (
                .e (even_beat[gi*LANE_W +: LANE_W]),
                .o (pixel_in[gi*LANE_W +: LANE_W]),
                .l (lo_calc[gi*LANE_W +: LANE_W]),
                .h (hi_calc[gi*LANE_W +: LANE_W])
            );
        end
    endgenerate

    // Even rows never stall; odd rows stall only when the output slot is occupied and not draining.
    always_comb begin
        in_ready  = (state_q == EVEN) ? 1'b1 : (!out_valid_q || out_ready);
        xfer      = in_valid && in_ready;
        rowbuf_we = xfer && (state_q == EVEN);
    end

    // Next-state: column/pair counters, row parity and the output slot.
    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        pair_cnt_d   = pair_cnt_q;
        out_valid_d  = out_valid_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        frame_done_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (xfer) begin
            col_cnt_d = (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + 1'b1;
            if (state_q == EVEN) begin
                if (col_cnt_q == COL_LAST) begin
                    state_d = ODD;
                end
            end else begin
                lo_d        = lo_calc;
                hi_d        = hi_calc;
                out_valid_d = 1'b1;
                if (col_cnt_q == COL_LAST) begin
                    state_d = EVEN;
                    if (pair_cnt_q == PAIR_LAST) begin
                        pair_cnt_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pair_cnt_d = pair_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // Control and output registers; reset aborts the frame and drops any pending pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EVEN;
            col_cnt_q    <= '0;
            pair_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            pair_cnt_q   <= pair_cnt_d;
            out_valid_q  <= out_valid_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row buffer write port, no reset needed since contents are written before use.
    always_ff @(posedge clk) begin
        if (rowbuf_we) begin
            rowbuf_q[col_cnt_q] <= pixel_in;
        end
    end

    assign out_valid  = out_valid_q;
    assign lo_out     = lo_q;
    assign hi_out     = hi_q;
    assign frame_done = frame_done_q;

endmodule
